// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU sequencer: datapath widths, sequencer
// state encodings (visible on state_dbg), opcode values and class helpers.
package mpu_pkg;

  localparam int unsigned DATA_W = 200;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_A    = 4'd1,
    S_RD_B    = 4'd2,
    S_EXEC    = 4'd3,
    S_WAIT_OP = 4'd4,
    S_WRITE   = 4'd5,
    S_DONE    = 4'd6
  } state_t;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_MUL       = 3'b010;
  localparam logic [2:0] OP_SMUL      = 3'b011;
  localparam logic [2:0] OP_TRANSPOSE = 3'b100;
  localparam logic [2:0] OP_NEGATE    = 3'b101;
  localparam logic [2:0] OP_DET       = 3'b110;
  localparam logic [2:0] OP_RSVD      = 3'b111;

  // Unary operations use only matrix A, so the B fetch is skipped.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_TRANSPOSE) || (op == OP_NEGATE) || (op == OP_DET);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/mpu_wait_counter.sv
// Loadable down-counter with terminal flag.
// Ports: clock, reset_n (async active-low), load/load_val (load wins),
// term (high while the count is zero). The count decrements every cycle
// and saturates at zero.
module mpu_wait_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         term
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign term = (count == '0);

endmodule

// File: rtl/mpu_sequencer.sv
// Start-triggered sequencer running one matrix operation on the MPU datapath:
// fetch A (and B for binary ops), pulse the operations unit, wait for its
// result (with timeout), write the result back, pulse done.
// Ports:
//   clock, reset_n                 clock and async active-low reset
//   start, opcode, base_a/b/r      request; latched when accepted in IDLE
//   mem_addr/wren/wdata, mem_rdata memory interface
//   op_opcode, matrix_a/b, op_start, op_done, op_result  operations unit
//   busy, done, error, state_dbg   status
module mpu_sequencer
  import mpu_pkg::*;
#(
  parameter int unsigned DATA_W     = mpu_pkg::DATA_W,
  parameter int unsigned ADDR_W     = mpu_pkg::ADDR_W,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned OP_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        op_opcode,
  output logic [DATA_W-1:0] matrix_a,
  output logic [DATA_W-1:0] matrix_b,
  output logic              op_start,
  input  logic              op_done,
  input  logic [DATA_W-1:0] op_result,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        state_dbg
);

  localparam int unsigned CNT_W = 8;
  // Counter is loaded with N-1 so that term marks the N-th cycle in the state.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(OP_TIMEOUT - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_b_q, base_r_q, addr_n;
  logic              cnt_load, cnt_term;
  logic [CNT_W-1:0]  cnt_val;
  logic              accept, cap_a, cap_b, cap_res, set_err;

  mpu_wait_counter #(.W(CNT_W)) u_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .term     (cnt_term)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_opcode <= '0;
      base_b_q  <= '0;
      base_r_q  <= '0;
      mem_addr  <= '0;
      matrix_a  <= '0;
      matrix_b  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      state    <= state_n;
      mem_addr <= addr_n;
      if (accept) begin
        op_opcode <= opcode;
        base_b_q  <= base_b;
        base_r_q  <= base_r;
      end
      if (cap_a)   matrix_a  <= mem_rdata;
      if (cap_b)   matrix_b  <= mem_rdata;
      if (cap_res) mem_wdata <= op_result;
      if (set_err)     error <= 1'b1;
      else if (accept) error <= 1'b0;
    end
  end

  // mem_addr is registered and updated on entry to each memory state, so it
  // is valid throughout the state and holds its last value otherwise.
  always_comb begin
    state_n  = state;
    addr_n   = mem_addr;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    cap_res  = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_n  = S_RD_A;
          addr_n   = base_a;
          cnt_load = 1'b1;
          cnt_val  = RD_LOAD;
        end
      end
      S_RD_A: begin
        if (cnt_term) begin
          cap_a = 1'b1;
          if (is_reserved(op_opcode)) begin
            set_err = 1'b1;
            state_n = S_DONE;
          end else if (is_unary(op_opcode)) begin
            state_n = S_EXEC;
          end else begin
            state_n  = S_RD_B;
            addr_n   = base_b_q;
            cnt_load = 1'b1;
            cnt_val  = RD_LOAD;
          end
        end
      end
      S_RD_B: begin
        if (cnt_term) begin
          cap_b   = 1'b1;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        state_n  = S_WAIT_OP;
        cnt_load = 1'b1;
        cnt_val  = TO_LOAD;
      end
      S_WAIT_OP: begin
        // A result arriving on the final timeout cycle still wins.
        if (op_done) begin
          cap_res = 1'b1;
          state_n = S_WRITE;
          addr_n  = base_r_q;
        end else if (cnt_term) begin
          set_err = 1'b1;
          state_n = S_DONE;
        end
      end
      S_WRITE: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_wren  = (state == S_WRITE);
  assign op_start  = (state == S_EXEC);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Self-checking bench for mpu_sequencer: directed scenarios plus randomized
// operations checked cycle-by-cycle against a timeline model.
module tb_mpu_sequencer;

  localparam int DW = 200;
  localparam int AW = 3;
  localparam int RL = 2;
  localparam int TO = 255;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    opcode = '0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_r = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    op_opcode;
  logic [DW-1:0] matrix_a, matrix_b;
  logic          op_start;
  logic          op_done = 1'b0;
  logic [DW-1:0] op_result = '0;
  logic          busy, done, error;
  logic [3:0]    state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_ma = '0, exp_mb = '0;
  logic          prev_err = 1'b0;

  mpu_sequencer #(.READ_LAT(RL), .OP_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .base_a(base_a), .base_b(base_b), .base_r(base_r),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .op_opcode(op_opcode), .matrix_a(matrix_a),
    .matrix_b(matrix_b), .op_start(op_start), .op_done(op_done),
    .op_result(op_result), .busy(busy), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Memory with READ_LAT=2: data is valid one cycle after the address.
  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] = mem_wdata;
  end

  function automatic logic [DW-1:0] rand_mat();
    logic [DW-1:0] m = '0;
    for (int i = 0; i < 7; i++) m = {m[DW-33:0], $urandom()};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_addr"}, DW'(mem_addr), '0);
    chk1({pfx, "_wren"}, mem_wren, 1'b0);
    chk({pfx, "_wdata"}, mem_wdata, '0);
    chk({pfx, "_opcode"}, DW'(op_opcode), '0);
    chk({pfx, "_ma"}, matrix_a, '0);
    chk({pfx, "_mb"}, matrix_b, '0);
    chk1({pfx, "_opstart"}, op_start, 1'b0);
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_done"}, done, 1'b0);
    chk1({pfx, "_error"}, error, 1'b0);
    chk({pfx, "_state"}, DW'(state_dbg), '0);
  endtask

  // One operation. k = cycles from op_start to op_done (0 = never).
  // glitch = pulse start with junk inputs two cycles after op_start.
  task automatic run_op(input logic [2:0] opc, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] r, input int k, input bit glitch,
                        input logic [DW-1:0] res);
    bit rsvd, unary, binop;
    int texec, topdone, twrite, tdone;
    logic exp_err;
    logic [DW-1:0] snap_a, snap_b, snap_r;
    logic [AW-1:0] eaddr;
    rsvd  = (opc == 3'b111);
    unary = (opc >= 3'b100) && !rsvd;
    binop = !rsvd && !unary;
    snap_a = mem[a]; snap_b = mem[b]; snap_r = mem[r];
    topdone = -1; twrite = -1; texec = -1;
    if (rsvd) begin
      tdone = RL + 1; exp_err = 1'b1;
    end else begin
      texec = unary ? RL + 1 : 2 * RL + 1;
      if (k > 0) begin
        topdone = texec + k; twrite = texec + k + 1; tdone = texec + k + 2; exp_err = 1'b0;
      end else begin
        tdone = texec + 1 + TO; exp_err = 1'b1;
      end
    end
    for (int c = 0; c <= tdone + 1; c++) begin
      @(negedge clock);
      start = (c == 0) || (glitch && c == texec + 2);
      if (c == 0) begin
        opcode = opc; base_a = a; base_b = b; base_r = r;
      end else begin
        opcode = 3'($urandom()); base_a = 3'($urandom());
        base_b = 3'($urandom()); base_r = 3'($urandom());
      end
      op_done   = (c == topdone);
      op_result = (c == topdone) ? res : rand_mat();
      chk1("busy", busy, (c >= 1) && (c <= tdone));
      chk1("op_start", op_start, c == texec);
      chk1("mem_wren", mem_wren, c == twrite);
      chk1("done", done, c == tdone);
      chk1("error", error, (c == 0) ? prev_err : ((c < tdone) ? 1'b0 : exp_err));
      if (c >= 1) begin
        if (twrite >= 0 && c >= twrite) eaddr = r;
        else if (binop && c > RL)       eaddr = b;
        else                            eaddr = a;
        chk("mem_addr", DW'(mem_addr), DW'(eaddr));
        chk("op_opcode", DW'(op_opcode), DW'(opc));
      end
      if (c == twrite) chk("mem_wdata", mem_wdata, res);
    end
    start = 1'b0; op_done = 1'b0;
    exp_ma = snap_a;
    if (binop) exp_mb = snap_b;
    chk("matrix_a", matrix_a, exp_ma);
    chk("matrix_b", matrix_b, exp_mb);
    chk("mem_result", mem[r], (twrite >= 0) ? res : snap_r);
    prev_err = exp_err;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = rand_mat();

    // Reset state
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk_zero("post_reset");

    // Add: reads 0 and 1, write 2 in cycle 9, done in cycle 10
    mem[0] = {25{8'h01}}; mem[1] = {25{8'h02}};
    run_op(3'b000, 3'd0, 3'd1, 3'd2, 3, 1'b0, {25{8'h03}});

    // Transpose: no B fetch, matrix_b kept
    run_op(3'b100, 3'd3, 3'd1, 3'd4, 2, 1'b0, rand_mat());

    // Reserved opcode, then a valid op clears error
    run_op(3'b111, 3'd5, 3'd6, 3'd7, 2, 1'b0, rand_mat());
    run_op(3'b010, 3'd5, 3'd6, 3'd7, 1, 1'b0, rand_mat());

    // Op timeout
    run_op(3'b001, 3'd2, 3'd3, 3'd6, 0, 1'b0, rand_mat());

    // Start during WAIT_OP is ignored
    run_op(3'b011, 3'd4, 3'd5, 3'd1, 6, 1'b1, rand_mat());

    // Reset asserted in RD_B
    for (int c = 0; c <= RL + 1; c++) begin
      @(negedge clock);
      start = (c == 0); opcode = 3'b000; base_a = 3'd1; base_b = 3'd2; base_r = 3'd3;
    end
    start = 1'b0;
    chk("rdb_state", DW'(state_dbg), DW'(4'd2));
    reset_n = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_ma = '0; exp_mb = '0; prev_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk_zero("after_abort");
    end

    // Randomized operations, including aliasing and reserved opcodes
    for (int n = 0; n < 24; n++) begin
      int k;
      k = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      if ($urandom_range(3, 0) == 0) mem[$urandom_range(7, 0)] = rand_mat();
      run_op(3'($urandom()), 3'($urandom()), 3'($urandom()), 3'($urandom()), k,
             bit'(k >= 3 && $urandom_range(1, 0) == 1), rand_mat());
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
